// File: rtl/bfloat16_sub_pipe_pkg.sv
// Shared bfloat16 field layout, special constants and inter-stage record types
// for the pipelined bfloat16 subtractor.
package bfloat16_sub_pipe_pkg;

   localparam int SIGN_BIT = 15;
   localparam int EXP_HI   = 14;
   localparam int EXP_LO   = 7;
   localparam int MANT_HI  = 6;
   localparam int EXP_W    = 8;
   localparam int MANT_W   = 7;
   localparam int BIAS     = 127;
   localparam int SIG_W    = 11;
   localparam int SUM_W    = SIG_W + 1;
   localparam int LZC_W    = 4;

   localparam logic [EXP_W-1:0] INF_EXP   = EXP_W'(2 * BIAS + 1);
   localparam logic [15:0]      NAN_VALUE = 16'h7FC0;

   // Operands after unpack and alignment; "l" is the larger-exponent operand.
   typedef struct packed {
      logic             nan;
      logic             sign_l;
      logic             sign_s;
      logic [EXP_W-1:0] exp_l;
      logic [SIG_W-1:0] sig_l;
      logic [SIG_W-1:0] sig_s;
   } align_t;

   typedef struct packed {
      logic             nan;
      logic             sign;
      logic [EXP_W-1:0] exp;
      logic [SUM_W-1:0] mag;
   } sum_t;

   // Zero exponent flushes the operand to zero; guard bits sit below the mantissa.
   function automatic logic [SIG_W-1:0] make_sig(input logic [EXP_W-1:0] e,
                                                 input logic [MANT_W-1:0] m);
      return (e == '0) ? '0 : {1'b1, m, 3'b000};
   endfunction

endpackage

// File: rtl/bfloat16_sub_pipe_lzc.sv
// Combinational 12-bit leading-zero counter used by the normalize stage.
// An all-zero input reports 12.
module bf16_lzc12
   import bfloat16_sub_pipe_pkg::*;
(
   input  logic [SUM_W-1:0] value,
   output logic [LZC_W-1:0] count
);

   always_comb begin
      count = LZC_W'(SUM_W);
      for (int i = 0; i < SUM_W; i++) begin
         if (value[i]) count = LZC_W'(SUM_W - 1 - i);
      end
   end

endmodule

// File: rtl/bfloat16_sub_pipe.sv
// Three-stage bfloat16 subtractor (a - b) with valid/ready handshakes:
// S1 unpack/align, S2 magnitude add/sub, S3 normalize/pack, truncating.
module bfloat16_sub_pipe
   import bfloat16_sub_pipe_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] result
);

   logic v1, v2, v3;
   logic ld1, ld2, ld3;

   align_t s1_next, s1_q;
   sum_t   s2_next, s2_q;

   logic [EXP_W-1:0] exp_a, exp_b, shift;
   logic [SIG_W-1:0] sig_a, sig_b, sig_small;
   logic             sign_a, sign_b, a_big;

   logic [LZC_W-1:0]  lz;
   logic [SUM_W-1:0]  norm;
   logic signed [9:0] exp_n;
   logic [15:0]       result_next;

   // A stage loads when empty or when its occupant moves on this cycle.
   assign ld3       = !v3 || out_ready;
   assign ld2       = !v2 || ld3;
   assign ld1       = !v1 || ld2;
   assign in_ready  = ld1;
   assign out_valid = v3;

   // S1: subtraction becomes addition of b with its sign flipped.
   always_comb begin
      exp_a     = a[EXP_HI:EXP_LO];
      exp_b     = b[EXP_HI:EXP_LO];
      sign_a    = a[SIGN_BIT];
      sign_b    = ~b[SIGN_BIT];
      sig_a     = make_sig(exp_a, a[MANT_HI:0]);
      sig_b     = make_sig(exp_b, b[MANT_HI:0]);
      a_big     = (exp_a >= exp_b);
      shift     = a_big ? (exp_a - exp_b) : (exp_b - exp_a);
      sig_small = a_big ? sig_b : sig_a;

      s1_next.nan    = (exp_a == INF_EXP) || (exp_b == INF_EXP);
      s1_next.sign_l = a_big ? sign_a : sign_b;
      s1_next.sign_s = a_big ? sign_b : sign_a;
      s1_next.exp_l  = a_big ? exp_a : exp_b;
      s1_next.sig_l  = a_big ? sig_a : sig_b;
      s1_next.sig_s  = (shift >= EXP_W'(SIG_W)) ? '0 : (sig_small >> shift);
   end

   // S2: an exact cancellation always yields +0.
   always_comb begin
      s2_next.nan = s1_q.nan;
      s2_next.exp = s1_q.exp_l;
      if (s1_q.sign_l == s1_q.sign_s) begin
         s2_next.mag  = {1'b0, s1_q.sig_l} + {1'b0, s1_q.sig_s};
         s2_next.sign = s1_q.sign_l;
      end else if (s1_q.sig_l > s1_q.sig_s) begin
         s2_next.mag  = {1'b0, s1_q.sig_l - s1_q.sig_s};
         s2_next.sign = s1_q.sign_l;
      end else if (s1_q.sig_s > s1_q.sig_l) begin
         s2_next.mag  = {1'b0, s1_q.sig_s - s1_q.sig_l};
         s2_next.sign = s1_q.sign_s;
      end else begin
         s2_next.mag  = '0;
         s2_next.sign = 1'b0;
      end
   end

   bf16_lzc12 u_lzc (
      .value (s2_q.mag),
      .count (lz)
   );

   // S3: the leading one is moved to bit 11; a carry (lz = 0) is the right-shift-by-one case.
   always_comb begin
      norm  = s2_q.mag << lz;
      exp_n = $signed({2'b00, s2_q.exp}) + 10'sd1 - $signed({6'b000000, lz});
      if (s2_q.nan)
         result_next = NAN_VALUE;
      else if (s2_q.mag == '0)
         result_next = {s2_q.sign, 15'h0000};
      else if (exp_n >= 10'sd255)
         result_next = {s2_q.sign, INF_EXP, 7'h00};
      else if (exp_n <= 10'sd0)
         result_next = {s2_q.sign, 15'h0000};
      else
         result_next = {s2_q.sign, exp_n[EXP_W-1:0], MANT_W'(norm >> (SUM_W - 1 - MANT_W))};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1     <= 1'b0;
         v2     <= 1'b0;
         v3     <= 1'b0;
         result <= 16'h0000;
      end else begin
         if (ld1) v1 <= in_valid;
         if (ld2) v2 <= v1;
         if (ld3) begin
            v3 <= v2;
            if (v2) result <= result_next;
         end
      end
   end

   // Datapath registers carry no reset; the valid bits qualify them.
   always_ff @(posedge clk) begin
      if (ld1 && in_valid) s1_q <= s1_next;
      if (ld2 && v1)       s2_q <= s2_next;
   end

endmodule

// File: tb/tb_bfloat16_sub_pipe.sv
// Directed self-checking bench for bfloat16_sub_pipe: arithmetic vectors,
// specials, streaming, backpressure and mid-stream reset.
module tb_bfloat16_sub_pipe;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] result;

   int checks = 0;
   int errors = 0;

   bfloat16_sub_pipe dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   // Sends one pair into an empty pipeline and waits (bounded) for its result.
   task automatic do_op(input logic [15:0] x, input logic [15:0] y,
                        output logic [15:0] r, output bit ok);
      bit acc;
      ok = 1'b0;
      r  = 16'hxxxx;
      @(negedge clk);
      a = x;
      b = y;
      in_valid = 1'b1;
      #1 acc = in_ready;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (out_valid) begin
            r  = result;
            ok = acc;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      a = 16'h0000;
      b = 16'h0000;
      #3;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
      end
      checks++;
      if (result !== 16'h0000) begin
         errors++;
         $display("[TB] FAIL reset_result: got %h expected 0000", result);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_idle: got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
      end
   endtask

   task automatic run_vectors(input string tag, input logic [47:0] vecs [], input int n);
      logic [15:0] r;
      bit ok;
      for (int i = 0; i < n; i++) begin
         do_op(vecs[i][47:32], vecs[i][31:16], r, ok);
         checks++;
         if (!ok || r !== vecs[i][15:0]) begin
            errors++;
            $display("[TB] FAIL %s %h-%h: got %h expected %h (handshake ok=%0d)",
                     tag, vecs[i][47:32], vecs[i][31:16], r, vecs[i][15:0], ok);
         end
      end
   endtask

   task automatic test_arith;
      logic [47:0] vecs [];
      vecs = new[10];
      vecs = '{48'h3F80_3F80_0000, 48'h4040_3F80_4000, 48'h3F80_BF80_4000,
               48'h3F80_4000_BF80, 48'h3FC0_3F00_3F80, 48'h4000_3F80_3F80,
               48'h3F80_BC00_3F81, 48'h3F80_3380_3F80, 48'h3F80_3A80_3F7F,
               48'h3F80_3A00_3F80};
      run_vectors("arith", vecs, 10);
   endtask

   task automatic test_specials;
      logic [47:0] vecs [];
      vecs = new[8];
      vecs = '{48'h7F7F_FF7F_7F80, 48'hFF7F_7F7F_FF80, 48'h7FC0_3F80_7FC0,
               48'h3F80_FF80_7FC0, 48'h0001_0000_0000, 48'h8000_0000_8000,
               48'h0000_0000_0000, 48'h0080_00C0_8000};
      run_vectors("special", vecs, 8);
   endtask

   task automatic test_back_to_back;
      logic [15:0] xa [4] = '{16'h4040, 16'h3F80, 16'h3FC0, 16'h7F7F};
      logic [15:0] xb [4] = '{16'h3F80, 16'h4000, 16'h3F00, 16'hFF7F};
      logic [15:0] xr [4] = '{16'h4000, 16'hBF80, 16'h3F80, 16'h7F80};
      bit exp_valid;
      out_ready = 1'b1;
      for (int t = 0; t < 10; t++) begin
         @(negedge clk);
         exp_valid = (t >= 3) && (t <= 6);
         checks++;
         if (out_valid !== exp_valid) begin
            errors++;
            $display("[TB] FAIL b2b_valid t=%0d: got %b expected %b", t, out_valid, exp_valid);
         end
         if (exp_valid) begin
            checks++;
            if (result !== xr[t-3]) begin
               errors++;
               $display("[TB] FAIL b2b_result t=%0d: got %h expected %h", t, result, xr[t-3]);
            end
         end
         if (t < 4) begin
            checks++;
            if (in_ready !== 1'b1) begin
               errors++;
               $display("[TB] FAIL b2b_in_ready t=%0d: got %b expected 1", t, in_ready);
            end
            a = xa[t];
            b = xb[t];
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
      end
   endtask

   task automatic test_backpressure;
      logic [15:0] xa [5] = '{16'h4040, 16'h3F80, 16'h3FC0, 16'h3F80, 16'h7F7F};
      logic [15:0] xb [5] = '{16'h3F80, 16'h4000, 16'h3F00, 16'hBC00, 16'hFF7F};
      logic [15:0] xr [5] = '{16'h4000, 16'hBF80, 16'h3F80, 16'h3F81, 16'h7F80};
      logic [15:0] got [5];
      logic [15:0] held;
      int idx = 0;
      int recv = 0;
      bit acc;
      held = 16'h0000;
      out_ready = 1'b0;
      for (int cyc = 0; cyc < 60 && recv < 5; cyc++) begin
         @(negedge clk);
         if (cyc == 4) held = result;
         if (cyc == 6) begin
            checks++;
            if (idx != 3 || in_ready !== 1'b0) begin
               errors++;
               $display("[TB] FAIL bp_stall: got accepted=%0d in_ready=%b expected 3/0", idx, in_ready);
            end
            checks++;
            if (out_valid !== 1'b1 || result !== held) begin
               errors++;
               $display("[TB] FAIL bp_hold: got out_valid=%b result=%h expected 1/%h", out_valid, result, held);
            end
            out_ready = 1'b1;
         end
         if (idx < 5) begin
            a = xa[idx];
            b = xb[idx];
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         #1;
         acc = in_valid && in_ready;
         if (out_valid && out_ready) begin
            got[recv] = result;
            recv++;
         end
         @(posedge clk);
         if (acc) idx++;
      end
      in_valid = 1'b0;
      checks++;
      if (recv != 5) begin
         errors++;
         $display("[TB] FAIL bp_count: got %0d results expected 5", recv);
      end
      for (int i = 0; i < recv; i++) begin
         checks++;
         if (got[i] !== xr[i]) begin
            errors++;
            $display("[TB] FAIL bp_order[%0d]: got %h expected %h", i, got[i], xr[i]);
         end
      end
   endtask

   task automatic test_reset_midstream;
      int stale = 0;
      @(negedge clk);
      out_ready = 1'b0;
      a = 16'h4040;
      b = 16'h3F80;
      in_valid = 1'b1;
      @(negedge clk);
      a = 16'h3F80;
      b = 16'h4000;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1) begin
         errors++;
         $display("[TB] FAIL mid_pre_valid: got %b expected 1", out_valid);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 16'h0000) begin
         errors++;
         $display("[TB] FAIL mid_async_clear: got out_valid=%b in_ready=%b result=%h expected 0/1/0000",
                  out_valid, in_ready, result);
      end
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (out_valid !== 1'b0) stale++;
      end
      checks++;
      if (stale != 0) begin
         errors++;
         $display("[TB] FAIL mid_stale: got %0d valid cycles expected 0", stale);
      end
      a = 16'h3F80;
      b = 16'hBF80;
      in_valid = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL mid_in_ready: got %b expected 1", in_ready);
      end
      for (int t = 1; t <= 3; t++) begin
         @(negedge clk);
         in_valid = 1'b0;
         checks++;
         if (out_valid !== (t == 3)) begin
            errors++;
            $display("[TB] FAIL mid_latency t=%0d: got %b expected %b", t, out_valid, (t == 3));
         end
      end
      checks++;
      if (result !== 16'h4000) begin
         errors++;
         $display("[TB] FAIL mid_result: got %h expected 4000", result);
      end
      @(negedge clk);
   endtask

   initial begin
      $display("[TB] starting bfloat16_sub_pipe bench");
      test_reset;
      test_arith;
      test_specials;
      test_back_to_back;
      test_backpressure;
      test_reset_midstream;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
